fp_acc_sequencer: RTL and testbench

FP_ACC_SEQUENCER -- requirements
Module: fp_acc_sequencer

---
 rtl/fp_acc_sequencer.sv | 102 ++++++++++
 tb/tb_fp_acc_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_acc_sequencer.sv
// Sequences a run of single-precision elements through an external combinational
// FP adder, accumulating them into one sum that is held until the consumer takes it.
module fp_acc_sequencer #(
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      add_op1,
  output logic [31:0]      add_op2,
  input  logic [31:0]      add_result,
  output logic [31:0]      sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= 32'h0;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = 32'h0;
          if (length != '0) begin
            cnt_d   = length;
            first_d = 1'b1;
            state_d = ACC;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          cnt_d = cnt_q - LEN_W'(1);
          // The external adder cannot take zero operands, so zeros bypass it.
          if (first_q) begin
            acc_d   = in_data;
            first_d = 1'b0;
          end else if (in_data[30:0] == 31'h0) begin
            acc_d = acc_q;
          end else if (acc_q[30:0] == 31'h0) begin
            acc_d = in_data;
          end else begin
            acc_d = add_result;
          end
          if (cnt_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ACC);
  assign sum_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = acc_q;
  assign add_op1   = acc_q;
  assign add_op2   = in_data;

endmodule

// File: tb/tb_fp_acc_sequencer.sv
// Self-checking bench for fp_acc_sequencer: directed scenarios plus randomized runs
// compared against a behavioural accumulation model driving a model FP adder.
module tb_fp_acc_sequencer;

  localparam int LEN_W = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             start;
  logic [LEN_W-1:0] length;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      add_op1;
  logic [31:0]      add_op2;
  logic [31:0]      add_result;
  logic [31:0]      sum_out;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;
  logic             poison_adder;

  int checks = 0;
  int passes = 0;

  fp_acc_sequencer #(.LEN_W(LEN_W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .length    (length),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_op1   (add_op1),
    .add_op2   (add_op2),
    .add_result(add_result),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  function automatic real sp_to_real(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'h0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    d = {b[31], e, b[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return 32'h0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return real_to_sp(sp_to_real(a) + sp_to_real(b));
  endfunction

  // Poisoning the adder makes any unwanted use of add_result visible in the sum.
  assign add_result = poison_adder ? 32'hDEADBEEF : fadd(add_op1, add_op2);

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = 8'($urandom_range(120, 134));
    if ($urandom_range(0, 3) == 0) return {r[31], 31'h0};
    return {r[31], e, r[22:0]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue_start(input int len);
    start  = 1'b1;
    length = LEN_W'(len);
    tick();
    start  = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    #1;
    aresetn = 1'b0;
    #2;
    checks++;
    if ({in_ready, sum_valid, busy} !== 3'b000)
      $display("[TB] FAIL reset_flags: got in_ready/sum_valid/busy=%b required 000", {in_ready, sum_valid, busy});
    else passes++;
    checks++;
    if (sum_out !== 32'h0) $display("[TB] FAIL reset_sum: got %h required 00000000", sum_out);
    else passes++;
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    poison_adder = 1'b1;
    issue_start(1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL single_acc: got in_ready=%b busy=%b required 1 1", in_ready, busy);
    else passes++;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1) $display("[TB] FAIL single_latency: got sum_valid=%b required 1", sum_valid);
    else passes++;
    checks++;
    if (sum_out !== 32'h3F800000) $display("[TB] FAIL single_sum: got %h required 3f800000", sum_out);
    else passes++;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL single_release: got sum_valid=%b busy=%b required 0 0", sum_valid, busy);
    else passes++;
    poison_adder = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h3F800000;
    vals[1] = 32'h40000000;
    vals[2] = 32'h40400000;
    issue_start(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || sum_valid !== 1'b0)
        $display("[TB] FAIL b2b_accept%0d: got in_ready=%b busy=%b sum_valid=%b required 1 1 0", i, in_ready, busy, sum_valid);
      else passes++;
      in_valid = 1'b1;
      in_data  = vals[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 32'h40C00000)
      $display("[TB] FAIL b2b_sum: got valid=%b sum=%h required 1 40c00000", sum_valid, sum_out);
    else passes++;
    tick();
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 32'h40C00000 || busy !== 1'b1)
      $display("[TB] FAIL b2b_hold: got valid=%b sum=%h busy=%b required 1 40c00000 1", sum_valid, sum_out, busy);
    else passes++;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_zero_length();
    issue_start(0);
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 32'h0 || in_ready !== 1'b0)
      $display("[TB] FAIL zero_len: got valid=%b sum=%h in_ready=%b required 1 00000000 0", sum_valid, sum_out, in_ready);
    else passes++;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL zero_len_idle: got busy=%b required 0", busy);
    else passes++;
  endtask

  task automatic test_zero_skip();
    poison_adder = 1'b1;
    issue_start(2);
    in_valid = 1'b1;
    in_data  = 32'h0;
    tick();
    in_data  = 32'hC0000000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 32'hC0000000)
      $display("[TB] FAIL zero_skip: got valid=%b sum=%h required 1 c0000000", sum_valid, sum_out);
    else passes++;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    poison_adder = 1'b0;
  endtask

  task automatic test_done_hold();
    issue_start(1);
    in_valid = 1'b1;
    in_data  = 32'h40490FDB;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start  = i[0];
      length = LEN_W'(3);
      tick();
      checks++;
      if (sum_valid !== 1'b1 || sum_out !== 32'h40490FDB || in_ready !== 1'b0)
        $display("[TB] FAIL done_hold%0d: got valid=%b sum=%h in_ready=%b required 1 40490fdb 0", i, sum_valid, sum_out, in_ready);
      else passes++;
    end
    // start coincides with the DONE->IDLE edge and must not launch a run.
    start     = 1'b1;
    sum_ready = 1'b1;
    tick();
    start     = 1'b0;
    sum_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || sum_valid !== 1'b0)
      $display("[TB] FAIL done_release: got busy=%b valid=%b required 0 0", busy, sum_valid);
    else passes++;
    tick();
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL done_start_ignored: got busy=%b required 0", busy);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    issue_start(4);
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    tick();
    in_data  = 32'h40000000;
    tick();
    in_valid = 1'b0;
    aresetn  = 1'b0;
    #1;
    checks++;
    if ({in_ready, sum_valid, busy} !== 3'b000 || sum_out !== 32'h0)
      $display("[TB] FAIL midrun_reset: got flags=%b sum=%h required 000 00000000", {in_ready, sum_valid, busy}, sum_out);
    else passes++;
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL midrun_wait: got busy=%b in_ready=%b required 0 0", busy, in_ready);
    else passes++;
    issue_start(1);
    in_valid = 1'b1;
    in_data  = 32'h41200000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sum_valid !== 1'b1 || sum_out !== 32'h41200000)
      $display("[TB] FAIL midrun_fresh: got valid=%b sum=%h required 1 41200000", sum_valid, sum_out);
    else passes++;
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic test_random_runs();
    for (int run = 0; run < 30; run++) begin
      int           len;
      int           idx;
      int           budget;
      int           hold;
      logic [31:0]  elems [$];
      logic [31:0]  expected;
      len = $urandom_range(1, 12);
      elems.delete();
      for (int i = 0; i < len; i++) elems.push_back(rand_fp());
      expected = 32'h0;
      for (int i = 0; i < len; i++) begin
        if (i == 0) expected = elems[i];
        else if (elems[i][30:0] == 31'h0) expected = expected;
        else if (expected[30:0] == 31'h0) expected = elems[i];
        else expected = fadd(expected, elems[i]);
      end
      issue_start(len);
      idx    = 0;
      budget = 200;
      while (idx < len && budget > 0) begin
        checks++;
        if (in_ready !== 1'b1 || sum_valid !== 1'b0)
          $display("[TB] FAIL rand_ready run%0d elem%0d: got in_ready=%b valid=%b required 1 0", run, idx, in_ready, sum_valid);
        else passes++;
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = in_valid ? elems[idx] : $urandom;
        if (in_valid && in_ready) idx++;
        tick();
        budget--;
      end
      in_valid = 1'b0;
      checks++;
      if (idx != len) $display("[TB] FAIL rand_timeout run%0d: accepted %0d required %0d", run, idx, len);
      else passes++;
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if (sum_valid !== 1'b1 || sum_out !== expected)
          $display("[TB] FAIL rand_sum run%0d: got valid=%b sum=%h required 1 %h", run, sum_valid, sum_out, expected);
        else passes++;
        if (h == hold) sum_ready = 1'b1;
        tick();
      end
      sum_ready = 1'b0;
      checks++;
      if (sum_valid !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL rand_idle run%0d: got valid=%b busy=%b required 0 0", run, sum_valid, busy);
      else passes++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start        = 1'b0;
    length       = '0;
    in_data      = 32'h0;
    in_valid     = 1'b0;
    sum_ready    = 1'b0;
    poison_adder = 1'b0;
    aresetn      = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_length();
    test_zero_skip();
    test_done_hold();
    test_reset_midrun();
    test_random_runs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
